// File: rtl/intersection_phase_ctrl.sv
// intersection_phase_ctrl
//   Actuated two-road intersection sequencer. It steps NS green/yellow, an
//   all-red clearance, EW green/yellow, a second all-red, and an optional
//   pedestrian WALK phase. Phase durations count tick_en strobes. A green is
//   held while the opposing road is idle and no pedestrian is waiting.
//   Light encoding: RED=2'b00, YELLOW=2'b01, GREEN=2'b10.
// Ports
//   clk       system clock, all state changes on posedge
//   rst       asynchronous active-high reset
//   tick_en   1-cycle timebase strobe; the phase counter advances only here
//   ns_car    vehicle waiting on the NS road (level)
//   ew_car    vehicle waiting on the EW road (level)
//   ped_req   pedestrian button (pulse or level)
//   ns_light  NS light (registered)
//   ew_light  EW light (registered)
//   walk      pedestrian WALK lamp (registered)
//   ped_wait  pedestrian request latched and not yet served
//   phase     current state code (debug)
module intersection_phase_ctrl #(
  parameter int unsigned GREEN_TICKS  = 5,
  parameter int unsigned YELLOW_TICKS = 2,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [CNT_W-1:0] last_s;
  logic             nxt_dir_r, nxt_dir_s;
  logic             ped_wait_r, ped_wait_s;
  logic             enter_walk_s;
  logic [1:0]       ns_s, ew_s;
  logic             walk_s;

  // Last count value of the current phase (duration minus one).
  always_comb begin
    last_s = '0;
    case (state_r)
      NS_G, EW_G: last_s = CNT_W'(GREEN_TICKS - 1);
      NS_Y, EW_Y: last_s = CNT_W'(YELLOW_TICKS - 1);
      AR_A, AR_B: last_s = CNT_W'(ALLRED_TICKS - 1);
      WALK:       last_s = CNT_W'(WALK_TICKS - 1);
      default:    last_s = '0;
    endcase
  end

  // Next-state, counter and direction-memory logic.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    nxt_dir_s = nxt_dir_r;
    if (tick_en) begin
      if (count_r == last_s) begin
        case (state_r)
          NS_G: begin
            if (ew_car || ped_wait_r) state_s = NS_Y;
            else                      state_s = NS_G;
          end
          NS_Y: state_s = AR_A;
          AR_A: begin
            if (ped_wait_r) begin
              state_s   = WALK;
              nxt_dir_s = DIR_EW;
            end else begin
              state_s   = EW_G;
            end
          end
          EW_G: begin
            if (ns_car || ped_wait_r) state_s = EW_Y;
            else                      state_s = EW_G;
          end
          EW_Y: state_s = AR_B;
          AR_B: begin
            if (ped_wait_r) begin
              state_s   = WALK;
              nxt_dir_s = DIR_NS;
            end else begin
              state_s   = NS_G;
            end
          end
          WALK: begin
            if (nxt_dir_r == DIR_NS) state_s = NS_G;
            else                     state_s = EW_G;
          end
          // Unused code 7: fall back to an all-red clearance.
          default: state_s = AR_B;
        endcase
        // A held green keeps its count at the last value so the hold
        // condition is re-evaluated on every later tick.
        if (state_s != state_r) count_s = '0;
        else                    count_s = count_r;
      end else begin
        count_s = count_r + CNT_ONE;
      end
    end else begin
      count_s = count_r;
    end
  end

  // Pedestrian latch: clearing on WALK entry takes priority over a new press.
  always_comb begin
    enter_walk_s = (state_s == WALK) && (state_r != WALK);
    if (enter_walk_s) ped_wait_s = 1'b0;
    else              ped_wait_s = ped_wait_r | ped_req;
  end

  // Light decode of the next state so the registered lights track the state.
  always_comb begin
    ns_s   = LT_RED;
    ew_s   = LT_RED;
    walk_s = 1'b0;
    case (state_s)
      NS_G:    ns_s   = LT_GREEN;
      NS_Y:    ns_s   = LT_YELLOW;
      EW_G:    ew_s   = LT_GREEN;
      EW_Y:    ew_s   = LT_YELLOW;
      WALK:    walk_s = 1'b1;
      default: walk_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= AR_B;
      count_r    <= '0;
      nxt_dir_r  <= DIR_NS;
      ped_wait_r <= 1'b0;
      ns_light   <= LT_RED;
      ew_light   <= LT_RED;
      walk       <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      nxt_dir_r  <= nxt_dir_s;
      ped_wait_r <= ped_wait_s;
      ns_light   <= ns_s;
      ew_light   <= ew_s;
      walk       <= walk_s;
    end
  end

  assign ped_wait = ped_wait_r;
  assign phase    = state_r;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// tb_intersection_phase_ctrl
//   Directed self-checking bench for intersection_phase_ctrl with default
//   parameters (green 5, yellow 2, all-red 1, walk 4 ticks).
module tb_intersection_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk;
  logic       ped_wait;
  logic [2:0] phase;

  int checks;
  int errors;

  // Expected phase after edge k of a busy cycle, index (k-1) % 16.
  logic [2:0] busy_tbl [16];

  intersection_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .ns_car   (ns_car),
    .ew_car   (ew_car),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_wait (ped_wait),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ns(input logic [2:0] p);
    case (p)
      3'd0:    return 2'b10;
      3'd1:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_ew(input logic [2:0] p);
    case (p)
      3'd3:    return 2'b10;
      3'd4:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Both roads busy, tick every clk: check n edges against the 16-tick cycle.
  task automatic run_busy(input string tag, input int n);
    logic [2:0] e;
    ns_car  = 1'b1;
    ew_car  = 1'b1;
    tick_en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step(1);
      e = busy_tbl[(k - 1) % 16];
      check_eq({tag, "_phase"}, 8'(phase), 8'(e));
      check_eq({tag, "_ns"}, 8'(ns_light), 8'(exp_ns(e)));
      check_eq({tag, "_ew"}, 8'(ew_light), 8'(exp_ew(e)));
      check_eq({tag, "_walk"}, 8'(walk), 8'd0);
    end
  endtask

  initial begin
    int bad;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    tick_en = 1'b0;
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    ped_req = 1'b0;
    busy_tbl = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};

    // Reset state
    step(2);
    check_eq("rst_phase", 8'(phase), 8'd5);
    check_eq("rst_ns", 8'(ns_light), 8'd0);
    check_eq("rst_ew", 8'(ew_light), 8'd0);
    check_eq("rst_walk", 8'(walk), 8'd0);
    check_eq("rst_pedw", 8'(ped_wait), 8'd0);

    // T1: busy roads, two full cycles
    rst = 1'b0;
    run_busy("t1", 32);

    // T2: idle roads hold NS green, then EW demand ends it on the next tick
    do_reset();
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    tick_en = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (ns_light != 2'b10 || ew_light != 2'b00) bad++;
    end
    check_eq("t2_hold_bad", 8'(bad), 8'd0);
    check_eq("t2_hold_phase", 8'(phase), 8'd0);
    tick_en = 1'b0;
    ew_car  = 1'b1;
    step(3);
    check_eq("t2_notick_ns", 8'(ns_light), 8'd2);
    tick_en = 1'b1;
    step(1);
    check_eq("t2_yel_ns", 8'(ns_light), 8'd1);
    check_eq("t2_yel_phase", 8'(phase), 8'd1);

    // T3: pedestrian served from NS green
    do_reset();
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    tick_en = 1'b1;
    step(2);                       // edge 2: NS_G count 1
    ped_req = 1'b1;
    step(1);                       // edge 3
    ped_req = 1'b0;
    check_eq("t3_pedw_set", 8'(ped_wait), 8'd1);
    check_eq("t3_still_g", 8'(phase), 8'd0);
    step(3);                       // edge 6
    check_eq("t3_nsy", 8'(phase), 8'd1);
    check_eq("t3_nsy_ns", 8'(ns_light), 8'd1);
    step(2);                       // edge 8
    check_eq("t3_ara", 8'(phase), 8'd2);
    step(1);                       // edge 9: WALK entry
    check_eq("t3_walk_phase", 8'(phase), 8'd6);
    check_eq("t3_walk", 8'(walk), 8'd1);
    check_eq("t3_walk_ns", 8'(ns_light), 8'd0);
    check_eq("t3_walk_ew", 8'(ew_light), 8'd0);
    check_eq("t3_pedw_clr", 8'(ped_wait), 8'd0);

    // T4: press during WALK is latched and served on the next cycle
    ped_req = 1'b1;
    step(1);                       // edge 10
    ped_req = 1'b0;
    check_eq("t4_pedw_again", 8'(ped_wait), 8'd1);
    check_eq("t4_walk_hold", 8'(walk), 8'd1);
    step(3);                       // edge 13: WALK ends towards EW
    check_eq("t4_ewg", 8'(phase), 8'd3);
    check_eq("t4_ewg_ew", 8'(ew_light), 8'd2);
    check_eq("t4_ewg_walk", 8'(walk), 8'd0);
    step(5);                       // edge 18
    check_eq("t4_ewy", 8'(phase), 8'd4);
    step(2);                       // edge 20
    check_eq("t4_arb", 8'(phase), 8'd5);
    ped_req = 1'b1;
    step(1);                       // edge 21: WALK entry with button held
    check_eq("t4_walk2", 8'(phase), 8'd6);
    check_eq("t4_clr_wins", 8'(ped_wait), 8'd0);
    ped_req = 1'b0;
    step(4);                       // edge 25: WALK ends towards NS
    check_eq("t4_nsg", 8'(phase), 8'd0);
    check_eq("t4_nsg_ns", 8'(ns_light), 8'd2);

    // T5: stall mid EW green
    ew_car = 1'b1;
    step(5);                       // edge 30: NS_Y
    check_eq("t5_nsy", 8'(phase), 8'd1);
    step(3);                       // edge 33: EW_G count 0
    check_eq("t5_ewg", 8'(phase), 8'd3);
    step(2);                       // edge 35: count 2
    tick_en = 1'b0;
    ew_car  = 1'b0;
    ns_car  = 1'b1;
    step(50);
    check_eq("t5_frz_phase", 8'(phase), 8'd3);
    check_eq("t5_frz_ew", 8'(ew_light), 8'd2);
    check_eq("t5_frz_ns", 8'(ns_light), 8'd0);
    tick_en = 1'b1;
    step(2);                       // count 4 if it was held at 2
    check_eq("t5_cnt_kept", 8'(phase), 8'd3);
    step(1);
    check_eq("t5_ewy", 8'(phase), 8'd4);
    check_eq("t5_ewy_ew", 8'(ew_light), 8'd1);

    // T6: asynchronous reset mid EW yellow
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_async_phase", 8'(phase), 8'd5);
    check_eq("t6_async_ns", 8'(ns_light), 8'd0);
    check_eq("t6_async_ew", 8'(ew_light), 8'd0);
    check_eq("t6_async_walk", 8'(walk), 8'd0);
    step(2);
    rst = 1'b0;
    run_busy("t6", 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
